// File: rtl/seven_seg_pkg.sv
// Shared segment encodings for the seven-segment scan driver.
// Patterns are active-high {g,f,e,d,c,b,a}; polarity is applied only at the pins.
package seven_seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'h3F;
   localparam seg_t SEG_1     = 7'h06;
   localparam seg_t SEG_2     = 7'h5B;
   localparam seg_t SEG_3     = 7'h4F;
   localparam seg_t SEG_4     = 7'h66;
   localparam seg_t SEG_5     = 7'h6D;
   localparam seg_t SEG_6     = 7'h7D;
   localparam seg_t SEG_7     = 7'h07;
   localparam seg_t SEG_8     = 7'h7F;
   localparam seg_t SEG_9     = 7'h6F;
   localparam seg_t SEG_A     = 7'h77;
   localparam seg_t SEG_B     = 7'h7C;
   localparam seg_t SEG_C     = 7'h39;
   localparam seg_t SEG_D     = 7'h5E;
   localparam seg_t SEG_E     = 7'h79;
   localparam seg_t SEG_F     = 7'h71;
   localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_seg_scan_hex_to_seg.sv
// Combinational hex nibble to active-high segment pattern.
// Values above 9 decode to letters A,b,C,d,E,F.
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output seg_t       seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (nib_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = SEG_A;
         4'hB: seg_o = SEG_B;
         4'hC: seg_o = SEG_C;
         4'hD: seg_o = SEG_D;
         4'hE: seg_o = SEG_E;
         4'hF: seg_o = SEG_F;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver with tear-free frame updates,
// leading-zero blanking and a per-slot anode dead cycle.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_en,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic POL = (ACTIVE_LOW != 0);

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
   logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
   logic [NUM_DIGITS-1:0]   ddp_q, ddp_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   logic                    tick;
   logic                    last;
   logic [3:0]              nib;
   seg_t                    dec_seg;
   logic [NUM_DIGITS-1:0]   zero_from;
   logic                    zacc;
   logic                    blank;
   logic [NUM_DIGITS-1:0]   onehot;

   assign tick       = enable && (cnt_q == CNT_LAST);
   assign last       = (idx_q == IDX_LAST);
   assign frame_done = tick && last;

   always_comb begin
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      sdp_d    = sdp_q;
      disp_d   = disp_q;
      ddp_d    = ddp_q;
      if (load) begin
         shadow_d = value_in;
         sdp_d    = dp_in;
      end
      if (tick) begin
         cnt_d = '0;
         if (last) begin
            idx_d  = '0;
            // A load on the boundary cycle bypasses the shadow so it is not lost.
            disp_d = load ? value_in : shadow_q;
            ddp_d  = load ? dp_in    : sdp_q;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else if (enable) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Output register is fed from next-state so pins track the index one cycle after the tick.
   assign nib = disp_d[4*int'(idx_d) +: 4];

   hex_to_seg u_dec (
      .nib_i (nib),
      .seg_o (dec_seg)
   );

   always_comb begin
      zacc      = 1'b1;
      zero_from = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zacc         = zacc & (disp_d[4*i +: 4] == 4'h0);
         zero_from[i] = zacc;
      end
   end

   assign blank  = lz_en && (idx_d != '0) && zero_from[idx_d] && !ddp_d[idx_d];
   assign onehot = NUM_DIGITS'(1) << idx_d;

   always_comb begin
      seg_d = (blank ? SEG_BLANK : dec_seg) ^ {7{POL}};
      dp_d  = (ddp_d[idx_d] & ~blank) ^ POL;
      an_d  = ((enable && (cnt_d != '0)) ? onehot : '0) ^ {NUM_DIGITS{POL}};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         sdp_q    <= '0;
         disp_q   <= '0;
         ddp_q    <= '0;
         seg_q    <= {7{POL}};
         dp_q     <= POL;
         an_q     <= {NUM_DIGITS{POL}};
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         sdp_q    <= sdp_d;
         disp_q   <= disp_d;
         ddp_q    <= ddp_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         an_q     <= an_d;
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with 4 digits, 4-clock slots, active-high pins.
module tb_seven_seg_scan;

   localparam logic [6:0] E0 = 7'h3F;
   localparam logic [6:0] E1 = 7'h06;
   localparam logic [6:0] E2 = 7'h5B;
   localparam logic [6:0] E3 = 7'h4F;
   localparam logic [6:0] E4 = 7'h66;
   localparam logic [6:0] E5 = 7'h6D;
   localparam logic [6:0] EA = 7'h77;
   localparam logic [6:0] EB = 7'h7C;
   localparam logic [6:0] EC = 7'h39;
   localparam logic [6:0] EF = 7'h71;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value_in = '0;
   logic [3:0]  dp_in = '0;
   logic        lz_en = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   int total = 0;
   int bad = 0;
   int fd_cnt;

   seven_seg_scan #(
      .NUM_DIGITS (4),
      .SCAN_DIV   (4),
      .ACTIVE_LOW (0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .load       (load),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .lz_en      (lz_en),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_fd(input string tag);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (frame_done === 1'b1) seen = 1'b1;
      end
      chk({tag, "_fd_wait"}, {7'd0, seen}, 8'd1);
   endtask

   task automatic check_slot(input string tag, input logic [3:0] exp_an,
                             input logic [6:0] exp_seg, input logic exp_dp);
      @(negedge clk);
      chk({tag, "_dead_an"}, {4'd0, an}, 8'd0);
      chk({tag, "_dead_seg"}, {1'b0, seg}, {1'b0, exp_seg});
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk({tag, "_an"}, {4'd0, an}, {4'd0, exp_an});
         chk({tag, "_seg"}, {1'b0, seg}, {1'b0, exp_seg});
         chk({tag, "_dp"}, {7'd0, dp}, {7'd0, exp_dp});
      end
   endtask

   task automatic load_mid(input logic [15:0] v, input logic [3:0] d);
      @(negedge clk);
      value_in = v;
      dp_in    = d;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
   endtask

   initial begin
      #2 reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_an", {4'd0, an}, 8'd0);
      chk("rst_seg", {1'b0, seg}, 8'd0);
      chk("rst_dp", {7'd0, dp}, 8'd0);
      chk("rst_fd", {7'd0, frame_done}, 8'd0);

      // basic scan of 1234
      reset    = 1'b0;
      enable   = 1'b1;
      value_in = 16'h1234;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
      wait_fd("t2");
      check_slot("t2_d0", 4'b0001, E4, 1'b0);
      check_slot("t2_d1", 4'b0010, E3, 1'b0);
      check_slot("t2_d2", 4'b0100, E2, 1'b0);
      check_slot("t2_d3", 4'b1000, E1, 1'b0);

      // letters and frame_done rate
      load_mid(16'hABCF, 4'b0000);
      wait_fd("t3");
      check_slot("t3_d0", 4'b0001, EF, 1'b0);
      check_slot("t3_d1", 4'b0010, EC, 1'b0);
      check_slot("t3_d2", 4'b0100, EB, 1'b0);
      check_slot("t3_d3", 4'b1000, EA, 1'b0);
      fd_cnt = 0;
      repeat (32) begin
         @(negedge clk);
         if (frame_done === 1'b1) fd_cnt++;
      end
      chk("t3_fd_count", 8'(fd_cnt), 8'd2);

      // leading-zero blanking
      lz_en = 1'b1;
      load_mid(16'h0050, 4'b0000);
      wait_fd("t4a");
      check_slot("t4a_d0", 4'b0001, E0, 1'b0);
      check_slot("t4a_d1", 4'b0010, E5, 1'b0);
      check_slot("t4a_d2", 4'b0100, 7'h00, 1'b0);
      check_slot("t4a_d3", 4'b1000, 7'h00, 1'b0);
      load_mid(16'h0000, 4'b0000);
      wait_fd("t4b");
      check_slot("t4b_d0", 4'b0001, E0, 1'b0);
      check_slot("t4b_d1", 4'b0010, 7'h00, 1'b0);
      check_slot("t4b_d2", 4'b0100, 7'h00, 1'b0);
      check_slot("t4b_d3", 4'b1000, 7'h00, 1'b0);
      load_mid(16'h0000, 4'b0100);
      wait_fd("t4c");
      check_slot("t4c_d0", 4'b0001, E0, 1'b0);
      check_slot("t4c_d1", 4'b0010, 7'h00, 1'b0);
      check_slot("t4c_d2", 4'b0100, E0, 1'b1);
      check_slot("t4c_d3", 4'b1000, 7'h00, 1'b0);
      lz_en = 1'b0;

      // load on the boundary beats the earlier mid-frame load
      load_mid(16'h1111, 4'b0000);
      wait_fd("t5");
      value_in = 16'h2222;
      load     = 1'b1;
      @(posedge clk);
      #1 load  = 1'b0;
      check_slot("t5_d0", 4'b0001, E2, 1'b0);
      check_slot("t5_d1", 4'b0010, E2, 1'b0);
      check_slot("t5_d2", 4'b0100, E2, 1'b0);
      check_slot("t5_d3", 4'b1000, E2, 1'b0);

      // pause mid-slot and resume with the remaining count
      @(negedge clk);
      @(negedge clk);
      chk("t6_pre_an", {4'd0, an}, 8'h01);
      enable = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("t6_hold_an", {4'd0, an}, 8'h00);
         chk("t6_hold_fd", {7'd0, frame_done}, 8'd0);
      end
      enable = 1'b1;
      @(negedge clk);
      chk("t6_res1_an", {4'd0, an}, 8'h01);
      chk("t6_res1_seg", {1'b0, seg}, {1'b0, E2});
      @(negedge clk);
      chk("t6_res2_an", {4'd0, an}, 8'h01);
      @(negedge clk);
      chk("t6_next_dead", {4'd0, an}, 8'h00);
      @(negedge clk);
      chk("t6_next_an", {4'd0, an}, 8'h02);

      // asynchronous reset mid-slot
      #3 reset = 1'b1;
      #1;
      chk("t1_rst_an", {4'd0, an}, 8'h00);
      chk("t1_rst_seg", {1'b0, seg}, 8'h00);
      chk("t1_rst_dp", {7'd0, dp}, 8'd0);
      chk("t1_rst_fd", {7'd0, frame_done}, 8'd0);
      repeat (2) @(negedge clk);
      chk("t1_rst_hold_an", {4'd0, an}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
